// File: rtl/jt49_env.sv
// jt49_env: envelope generator fed by the envelope-period divider.
// Walks a 16- or 32-step ramp shaped by {CONT,ATT,ALT,HOLD} and
// registers a 5-bit envelope level for the amplitude stage.
// Build option: define JT49_ENV_YM32_EN for the YM2149 32-step ramp;
// leave it undefined for the AY-3-8910 16-step ramp.
module jt49_env #(
  parameter int STEP_EDGE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       step,
  input  logic       restart,
  input  logic [3:0] ctrl,
  output logic [4:0] env,
  output logic       busy
);

`ifdef JT49_ENV_YM32_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} st_t;

  // ATT only sets the starting direction at restart, so it is not kept.
  logic [CW-1:0] cnt, cnt_nx;
  logic          inv, inv_nx;
  logic          shp_cont, shp_alt, shp_hold;
  logic          shp_cont_nx, shp_alt_nx, shp_hold_nx;
  st_t           st, st_nx;
  logic          step_l, step_ev;
  logic [CW-1:0] lvl_nx;

  // Map a ramp level to the 5-bit output; the 16-step ramp duplicates its
  // MSB into the LSB so both ends still reach 0 and 31.
  function automatic logic [4:0] map_lvl(input logic [CW-1:0] lvl);
`ifdef JT49_ENV_YM32_EN
    return lvl;
`else
    return {lvl, lvl[CW-1]};
`endif
  endfunction

  // Step event detection on the divider's toggling output
  always_comb begin
    if (STEP_EDGE != 0) step_ev = cen & (step ^ step_l);
    else                step_ev = cen & step & ~step_l;
  end

  // Next-state: restart wins over a same-cycle step event
  always_comb begin
    cnt_nx      = cnt;
    inv_nx      = inv;
    st_nx       = st;
    shp_cont_nx = shp_cont;
    shp_alt_nx  = shp_alt;
    shp_hold_nx = shp_hold;
    if (restart) begin
      shp_cont_nx = ctrl[3];
      shp_alt_nx  = ctrl[1];
      shp_hold_nx = ctrl[0];
      cnt_nx      = '0;
      inv_nx      = ~ctrl[2];
      st_nx       = ST_RUN;
    end else if (st == ST_RUN && step_ev) begin
      if (cnt != CMAX) begin
        cnt_nx = cnt + CW'(1);
      end else if (!shp_cont) begin
        // one-shot shapes always park at level 0
        st_nx  = ST_STOP;
        inv_nx = 1'b1;
        cnt_nx = CMAX;
      end else if (shp_hold) begin
        st_nx  = ST_STOP;
        inv_nx = inv ^ shp_alt;
      end else begin
        cnt_nx = '0;
        inv_nx = inv ^ shp_alt;
      end
    end
    lvl_nx = cnt_nx ^ {CW{inv_nx}};
  end

  // State, step history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      inv      <= 1'b0;
      shp_cont <= 1'b0;
      shp_alt  <= 1'b0;
      shp_hold <= 1'b0;
      st       <= ST_STOP;
      step_l   <= 1'b0;
      env      <= 5'd0;
      busy     <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      inv      <= inv_nx;
      shp_cont <= shp_cont_nx;
      shp_alt  <= shp_alt_nx;
      shp_hold <= shp_hold_nx;
      st       <= st_nx;
      if (cen) step_l <= step;
      env      <= map_lvl(lvl_nx);
      busy     <= (st_nx == ST_RUN);
    end
  end

endmodule

// File: tb/tb_jt49_env.sv
// tb_jt49_env: directed bench for jt49_env; expected levels follow the
// build (JT49_ENV_YM32_EN selects the 32-step ramp).
module tb_jt49_env;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       step;
  logic       restart;
  logic [3:0] ctrl;
  logic [4:0] env;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

`ifdef JT49_ENV_YM32_EN
  localparam int MAXV   = 31;
  localparam int E_ONE  = 1;   // level 1 on the 32-step ramp
  localparam int E_MAX1 = 30;  // level MAX-1
`else
  localparam int MAXV   = 15;
  localparam int E_ONE  = 2;   // level 1 -> 00010
  localparam int E_MAX1 = 29;  // level 14 -> 11101
`endif

  jt49_env dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .step   (step),
    .restart(restart),
    .ctrl   (ctrl),
    .env    (env),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic int emap(input int lvl);
    logic [4:0] l;
    l = lvl[4:0];
`ifdef JT49_ENV_YM32_EN
    return int'(l);
`else
    return int'({l[3:0], l[3]});
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_restart(input logic [3:0] c);
    @(negedge clk);
    ctrl    = c;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic do_step();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; step = 1'b0; restart = 1'b0; ctrl = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_env", int'(env), 0);
    check("rst_busy", int'(busy), 0);
    do_step();
    check("stop_env", int'(env), 0);
    check("stop_busy", int'(busy), 0);

    // sawtooth up, repeating
    do_restart(4'b1100);
    check("saw_init", int'(env), 0);
    check("saw_busy", int'(busy), 1);
    do_step();
    check("saw_one", int'(env), E_ONE);
    for (int k = 2; k <= MAXV; k++) begin
      do_step();
      check("saw_ramp", int'(env), emap(k));
    end
    check("saw_top", int'(env), 31);
    do_step();
    check("saw_wrap", int'(env), 0);
    check("saw_busy2", int'(busy), 1);

    // triangle, up first
    do_restart(4'b1110);
    check("tri_init", int'(env), 0);
    for (int k = 1; k <= MAXV; k++) begin
      do_step();
      check("tri_up", int'(env), emap(k));
    end
    do_step();
    check("tri_turn", int'(env), 31);
    for (int k = 1; k <= MAXV; k++) begin
      do_step();
      check("tri_down", int'(env), emap(MAXV - k));
    end
    check("tri_bot", int'(env), 0);

    // one-shot attack, ends at 0
    do_restart(4'b0100);
    for (int k = 1; k <= MAXV; k++) do_step();
    check("att_top", int'(env), 31);
    do_step();
    check("att_end", int'(env), 0);
    check("att_busy", int'(busy), 0);
    repeat (3) do_step();
    check("att_stay", int'(env), 0);

    // decay then hold at 31
    do_restart(4'b1011);
    check("dh_init", int'(env), 31);
    for (int k = 1; k <= MAXV; k++) begin
      do_step();
      check("dh_down", int'(env), emap(MAXV - k));
    end
    do_step();
    check("dh_hold", int'(env), 31);
    check("dh_busy", int'(busy), 0);
    repeat (2) do_step();
    check("dh_stay", int'(env), 31);

    // restart together with a rising step: the step is lost
    @(negedge clk);
    ctrl = 4'b1000; restart = 1'b1; step = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_init", int'(env), 31);
    check("rs_busy", int'(busy), 1);
    step = 1'b0;
    @(negedge clk);
    check("rs_lost", int'(env), 31);
    do_step();
    check("rs_next", int'(env), E_MAX1);

    // step activity while cen is low shows up as one event
    @(negedge clk);
    cen = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    check("cen_hold", int'(env), E_MAX1);
    cen = 1'b1;
    @(negedge clk);
    check("cen_event", int'(env), emap(MAXV - 2));
    step = 1'b0;
    @(negedge clk);

    // ctrl change without restart is ignored
    ctrl = 4'b1111;
    do_step();
    check("ctrl_ign", int'(env), emap(MAXV - 3));
    check("ctrl_busy", int'(busy), 1);

    // asynchronous reset mid-ramp
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_env", int'(env), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_step();
    check("arst_step", int'(env), 0);
    check("arst_busy2", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
